pixel_shift_display: RTL and testbench
======================================

PIXEL_SHIFT_DISPLAY -- requirements
Module: pixel_shift_display

Interface
REQ-001 Parameter DIGITS, default 8: number of 7-segment digits; 8 segment bits per digit, N = DIGITS*8 total bits.
REQ-002 Parameter CLK_DIV, default 2: sclk half-period in clk cycles; legal range 1..255.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means each segment bit is inverted before shifting (lit = 0).
REQ-004 Parameter BLINK_BITS, default 24: width of the blink counter; only meaningful with PIXEL_BLINK_EN.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 load  input  1  request to send a new frame; sampled each clk.
REQ-008 seg_in  input  N  frame data; digit d occupies bits [8d+7:8d], bit 1 = segment lit.
REQ-009 blink_mask  input  DIGITS  per-digit blink enable; present only with PIXEL_BLINK_EN.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 sclk  output  1  serial shift clock to the external shift-register chain.
REQ-012 sdata  output  1  serial data, MSB of frame first.
REQ-013 slatch  output  1  storage-register latch strobe, active high.
REQ-014 done  output  1  one-clk pulse marking frame completion.

Function
REQ-015 FSM states: IDLE, SHIFT, LATCH, DONE; IDLE->SHIFT on load=1; SHIFT->LATCH after N bits; LATCH->DONE after CLK_DIV cycles; DONE->IDLE after 1 cycle.
REQ-016 In IDLE with load=1, the block SHALL snapshot seg_in (inverted bitwise if ACTIVE_LOW=1) into an N-bit shift register and set the bit counter to N in the same cycle.
REQ-017 load while busy=1 SHALL be ignored; no queueing; seg_in changes after acceptance SHALL not affect the frame in flight.
REQ-018 Each bit in SHIFT: sdata = shift-register MSB, sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles; sdata SHALL be stable across the whole bit period, including the sclk rising edge.
REQ-019 At the end of each sclk-high phase, the shift register SHALL shift left by 1 and the counter SHALL decrement by 1; at counter 0, the FSM SHALL enter LATCH with sclk=0.
REQ-020 In LATCH, slatch=1 for exactly CLK_DIV cycles and sclk=0; slatch=0 in all other states.
REQ-021 done=1 only in DONE; busy falls in the cycle after DONE, so load is accepted again from that cycle.
REQ-022 Latency from the load-accept cycle (cycle 0) to done: 1 + 2*CLK_DIV*N + CLK_DIV cycles; exactly N sclk rising edges per frame.
REQ-023 sdata SHALL be 0 in IDLE, LATCH and DONE.
REQ-024 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits and the bit counter ceil(log2(N+1)) bits; no wrap occurs within legal parameters.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, sclk=0, sdata=0, slatch=0, done=0, and clear the shift register, counters and blink counter, including in the middle of SHIFT or LATCH.
REQ-026 After release, the block SHALL accept load on the first clk edge where rst_n=1; no partial frame resumes.

Configuration
REQ-027 Macro PIXEL_BLINK_EN defined: the blink_mask port and a free-running BLINK_BITS counter exist; at snapshot, when the counter MSB=1, each digit d with blink_mask[d]=1 SHALL be loaded as blank (all segments off after ACTIVE_LOW handling).
REQ-028 PIXEL_BLINK_EN undefined: there is no blink_mask port and no counter; the snapshot is seg_in only.

Verification
REQ-029 DIGITS=8, CLK_DIV=1, ACTIVE_LOW=0, seg_in=64'h8000_0000_0000_0001, load pulse -> sdata=1 at sclk rising edges 1 and 64, otherwise 0; 64 edges; slatch high 1 cycle; done at cycle 130.
REQ-030 Same configuration with ACTIVE_LOW=1, seg_in=64'h0 -> all 64 sampled bits=1; done at cycle 130.
REQ-031 CLK_DIV=2, load held high for 300 cycles -> frames complete at cycles 259 and 519 (re-accept at 260); busy=0 only at cycle 260.
REQ-032 rst_n pulsed low at cycle 40 of a frame -> outputs 0 within the same cycle, no slatch or done; new load after release -> full frame with correct latency.
REQ-033 seg_in changed every cycle during SHIFT -> shifted bits match the value captured at the load-accept cycle.
REQ-034 PIXEL_BLINK_EN, BLINK_BITS=4, blink_mask=8'h01, seg_in all ones, ACTIVE_LOW=0 -> digit 0 (last 8 bits) shifted as 0 when loaded with counter MSB=1 and as 1 when loaded with MSB=0.

Source files
------------

// File: rtl/pixel_shift_display.sv
// Serialises a DIGITS x 8-bit 7-segment frame into an external shift-register chain (sclk/sdata/slatch).
// Define PIXEL_BLINK_EN to add the blink_mask port and a free-running blink counter.
module pixel_shift_display #(
  parameter int DIGITS     = 8,
  parameter int CLK_DIV    = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DIGITS*8-1:0]   seg_in,
`ifdef PIXEL_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic                  busy,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  slatch,
  output logic                  done
);

  localparam int N  = DIGITS * 8;
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(N + 1);
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV must be in 1..255");
  end
  if (BLINK_BITS < 1) begin : g_bad_blink_bits
    $error("BLINK_BITS must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            phase_q, phase_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [N-1:0]    sreg_q, sreg_d;
  logic [N-1:0]    frame_raw;
  logic [N-1:0]    frame;
  logic            half_end;

  assign half_end = (hcnt_q == HMAX);

`ifdef PIXEL_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= '0;
    else        blink_q <= blink_q + BLINK_BITS'(1);
  end

  // Blanked digits are zeroed before polarity handling so they come out dark either way.
  always_comb begin
    frame_raw = seg_in;
    for (int d = 0; d < DIGITS; d++) begin
      if (blink_q[BLINK_BITS-1] && blink_mask[d]) frame_raw[8*d +: 8] = 8'h00;
    end
  end
`else
  assign frame_raw = seg_in;
`endif

  assign frame = (ACTIVE_LOW != 0) ? ~frame_raw : frame_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SHIFT;
      S_SHIFT: if (half_end && phase_q && bcnt_q == BW'(1)) state_d = S_LATCH;
      S_LATCH: if (half_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // phase_q selects the sclk-low (0) or sclk-high (1) half of the current bit.
  always_comb begin
    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    case (state_q)
      S_IDLE: begin
        hcnt_d  = '0;
        phase_d = 1'b0;
        if (load) begin
          sreg_d = frame;
          bcnt_d = BW'(N);
        end
      end
      S_SHIFT: begin
        if (half_end) begin
          hcnt_d  = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            sreg_d = {sreg_q[N-2:0], 1'b0};
            bcnt_d = bcnt_q - BW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_LATCH: hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
      default: hcnt_d = '0;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    sclk   = (state_q == S_SHIFT) && phase_q;
    sdata  = (state_q == S_SHIFT) && sreg_q[N-1];
    slatch = (state_q == S_LATCH);
    done   = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_pixel_shift_display.sv
// Directed bench for pixel_shift_display: three instances (CLK_DIV/ACTIVE_LOW variants) checked
// for frame bits, sclk edge count, latch width, done latency, load-while-busy and mid-frame reset.
module tb_pixel_shift_display;

  logic        clk;
  logic        rst_n;
  logic [2:0]  load_w;
  logic [63:0] seg_in;
  logic [2:0]  busy_w, sclk_w, sdata_w, slatch_w, done_w;
`ifdef PIXEL_BLINK_EN
  logic [7:0]  blink_mask;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int sel = 0;

  logic m_busy, m_sclk, m_sdata, m_slatch, m_done;

  always_comb begin
    m_busy   = busy_w[sel];
    m_sclk   = sclk_w[sel];
    m_sdata  = sdata_w[sel];
    m_slatch = slatch_w[sel];
    m_done   = done_w[sel];
  end

  // dut 0: CLK_DIV=1 ACTIVE_LOW=0; dut 1: CLK_DIV=1 ACTIVE_LOW=1; dut 2: CLK_DIV=2 ACTIVE_LOW=1
  pixel_shift_display #(.DIGITS(8), .CLK_DIV(1), .ACTIVE_LOW(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load(load_w[0]), .seg_in(seg_in),
`ifdef PIXEL_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .busy(busy_w[0]), .sclk(sclk_w[0]), .sdata(sdata_w[0]), .slatch(slatch_w[0]), .done(done_w[0]));

  pixel_shift_display #(.DIGITS(8), .CLK_DIV(1), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load_w[1]), .seg_in(seg_in),
`ifdef PIXEL_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .busy(busy_w[1]), .sclk(sclk_w[1]), .sdata(sdata_w[1]), .slatch(slatch_w[1]), .done(done_w[1]));

  pixel_shift_display #(.DIGITS(8), .CLK_DIV(2), .ACTIVE_LOW(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load(load_w[2]), .seg_in(seg_in),
`ifdef PIXEL_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .busy(busy_w[2]), .sclk(sclk_w[2]), .sdata(sdata_w[2]), .slatch(slatch_w[2]), .done(done_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Load one frame on dut s at the next negedge (cycle 0) and watch it to completion.
  task automatic run_frame(input int s, input logic [63:0] seg, input logic [63:0] exp_bits,
                           input int cdiv, input bit scramble, input string tag);
    int          exp_done;
    int          edges, latch_n, done_at, bad, glitch;
    logic        busy_after, sdata_after, prev_sclk, prev_sdata;
    logic [63:0] cap;
    bit          finished;
    exp_done = 1 + 2 * cdiv * 64 + cdiv;
    edges = 0; latch_n = 0; done_at = -1; bad = 0; glitch = 0;
    busy_after = 1'b1; sdata_after = 1'b1; prev_sclk = 1'b0; prev_sdata = 1'b0;
    cap = '0; finished = 1'b0;
    sel = s;
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, 64'(m_busy), 64'd0);
    seg_in = seg;
    load_w[s] = 1'b1;
    for (int cyc = 1; cyc <= exp_done + 20 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) load_w[s] = 1'b0;
      if (cyc == 10) begin
        seg_in = ~seg;
        load_w[s] = 1'b1;
      end
      if (cyc == 11) load_w[s] = 1'b0;
      if (scramble) seg_in = {$urandom, $urandom};
      if (done_at >= 0) begin
        busy_after  = m_busy;
        sdata_after = m_sdata;
        finished    = 1'b1;
      end else begin
        if (m_sclk && !prev_sclk) begin
          edges++;
          cap = {cap[62:0], m_sdata};
          if (m_sdata !== prev_sdata) glitch++;
        end
        if (m_slatch) begin
          latch_n++;
          if (m_sdata || m_sclk) bad++;
        end
        if (m_done) begin
          done_at = cyc;
          if (m_sdata || m_sclk || m_slatch) bad++;
        end
        prev_sclk  = m_sclk;
        prev_sdata = m_sdata;
      end
    end
    check_eq({tag, "_bits"}, cap, exp_bits);
    check_eq({tag, "_sclk_edges"}, 64'(edges), 64'd64);
    check_eq({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    check_eq({tag, "_latch_cycles"}, 64'(latch_n), 64'(cdiv));
    check_eq({tag, "_sdata_stable"}, 64'(glitch), 64'd0);
    check_eq({tag, "_latch_done_quiet"}, 64'(bad), 64'd0);
    check_eq({tag, "_busy_after_done"}, 64'(busy_after), 64'd0);
    check_eq({tag, "_sdata_idle"}, 64'(sdata_after), 64'd0);
  endtask

  initial begin
    int done1, done2, busy_low_n, busy_low_at, ev;
    rst_n  = 1'b0;
    load_w = '0;
    seg_in = '0;
`ifdef PIXEL_BLINK_EN
    blink_mask = '0;
`endif
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {49'd0, busy_w, sclk_w, sdata_w, slatch_w, done_w}, 64'd0);
    rst_n = 1'b1;

    // Single set bits at both ends of the frame, no inversion.
    run_frame(0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1, 1'b0, "edge_bits");
    // Active-low: an all-dark frame shifts out as all ones.
    run_frame(1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, "active_low_zero");
    // seg_in churns every cycle after acceptance.
    run_frame(0, 64'hDEAD_BEEF_0BAD_F00D, 64'hDEAD_BEEF_0BAD_F00D, 1, 1'b1, "scramble_cd1");
    run_frame(2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2, 1'b1, "scramble_cd2");

    // load held high: back-to-back frames with one idle cycle between them.
    sel = 2;
    done1 = -1; done2 = -1; busy_low_n = 0; busy_low_at = -1;
    @(negedge clk);
    seg_in = 64'hFFFF_0000_FFFF_0000;
    load_w[2] = 1'b1;
    for (int cyc = 1; cyc <= 519; cyc++) begin
      @(negedge clk);
      if (m_done) begin
        if (done1 < 0) done1 = cyc;
        else if (done2 < 0) done2 = cyc;
      end
      if (!m_busy) begin
        busy_low_n++;
        busy_low_at = cyc;
      end
      if (cyc == 519) load_w[2] = 1'b0;
    end
    check_eq("hold_done1", 64'(done1), 64'd259);
    check_eq("hold_done2", 64'(done2), 64'd519);
    check_eq("hold_busy_low_count", 64'(busy_low_n), 64'd1);
    check_eq("hold_busy_low_cycle", 64'(busy_low_at), 64'd260);
    @(negedge clk);
    check_eq("hold_idle_after", 64'(m_busy), 64'd0);

    // Reset asserted at cycle 40 of a frame.
    @(negedge clk);
    seg_in = 64'h1234_5678_9ABC_DEF0;
    load_w[2] = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) load_w[2] = 1'b0;
    end
    check_eq("pre_reset_busy", 64'(m_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_frame_outputs",
             {59'd0, m_busy, m_sclk, m_sdata, m_slatch, m_done}, 64'd0);
    ev = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_slatch || m_done || m_busy) ev++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if (m_slatch || m_done || m_busy) ev++;
    check_eq("reset_no_resume", 64'(ev), 64'd0);
    run_frame(2, 64'h00FF_00FF_AA55_3C3C, 64'hFF00_FF00_55AA_C3C3, 2, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
